// File: rtl/id_hazard_scoreboard.sv
// Decode-stage RAW interlock: per-GPR pending-writer counters fed by issue and
// write-back retire, stalling decode while any source still has a writer in flight.
module id_hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ds_valid,
  input  logic        es_allowin,
  input  logic        ds_we,
  input  logic [4:0]  ds_dest,
  input  logic [4:0]  ds_rs,
  input  logic        ds_rs_used,
  input  logic [4:0]  ds_rt,
  input  logic        ds_rt_used,
  input  logic        ws_we,
  input  logic [4:0]  ws_dest,
  output logic        ds_stall,
  output logic        issue_fire,
  output logic [31:0] busy_vec,
  output logic        idle,
  output logic        err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W:0]   tot;

  logic hazard_rs, hazard_rt, full_dest;
  logic inc, ret, ret_ok, ret_underflow;

  // Saturating counter step: never above CNT_MAX, never below zero.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic up, input logic dn);
    logic [CNT_W-1:0] r;
    r = cur;
    if (up && !dn && cur != CNT_MAX)
      r = cur + 1'b1;
    else if (dn && !up && cur != '0)
      r = cur - 1'b1;
    return r;
  endfunction

  always_comb begin
    hazard_rs  = ds_rs_used & (ds_rs != 5'd0) & (cnt[ds_rs] != '0);
    hazard_rt  = ds_rt_used & (ds_rt != 5'd0) & (cnt[ds_rt] != '0);
    full_dest  = ds_we & (ds_dest != 5'd0) & (cnt[ds_dest] == CNT_MAX);
    ds_stall   = ds_valid & (hazard_rs | hazard_rt | full_dest);
    issue_fire = ds_valid & es_allowin & ~ds_stall & ~flush;
    inc        = issue_fire & ds_we & (ds_dest != 5'd0);
    ret        = ws_we & (ws_dest != 5'd0) & ~flush;
    // A retire against an empty counter is an error and must not move tot.
    ret_ok        = ret & (cnt[ws_dest] != '0);
    ret_underflow = ret & (cnt[ws_dest] == '0);
    idle       = (tot == '0);
  end

  always_comb begin
    for (int i = 0; i < 32; i++)
      busy_vec[i] = (cnt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < 32; i++)
        cnt[i] <= '0;
      tot <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < 32; i++)
        cnt[i] <= cnt_next(cnt[i], inc && (ds_dest == 5'(i)), ret_ok && (ws_dest == 5'(i)));
      tot <= tot + (CNT_W+1)'(inc) - (CNT_W+1)'(ret_ok);
    end
  end

  // Sticky error survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      err_underflow <= 1'b0;
    else if (ret_underflow)
      err_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: expectations queued at stimulus time,
// popped and compared against DUT outputs after each step settles.
module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        ds_valid, es_allowin, ds_we;
  logic [4:0]  ds_dest, ds_rs, ds_rt, ws_dest;
  logic        ds_rs_used, ds_rt_used, ws_we;
  logic        ds_stall, issue_fire, idle, err_underflow;
  logic [31:0] busy_vec;

  int ncmp = 0;
  int nfail = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

  id_hazard_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ds_valid(ds_valid), .es_allowin(es_allowin), .ds_we(ds_we), .ds_dest(ds_dest),
    .ds_rs(ds_rs), .ds_rs_used(ds_rs_used), .ds_rt(ds_rt), .ds_rt_used(ds_rt_used),
    .ws_we(ws_we), .ws_dest(ws_dest),
    .ds_stall(ds_stall), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .idle(idle), .err_underflow(err_underflow)
  );

  task automatic push(input string tag, input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    item_t it;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
      return;
    end
    it = sb.pop_front();
    ncmp++;
    assert (obs === it.exp) else begin
      nfail++;
      $error("FAIL %s observed=%h required=%h", it.tag, obs, it.exp);
    end
  endtask

  // Queue the four status expectations, then compare them in the same order.
  task automatic check_state(input string tag, input logic stall, input logic [31:0] busy,
                             input logic idl, input logic err);
    push({tag, "_stall"}, {31'd0, stall});
    push({tag, "_busy"}, busy);
    push({tag, "_idle"}, {31'd0, idl});
    push({tag, "_err"}, {31'd0, err});
    #1;
    pop_cmp({31'd0, ds_stall});
    pop_cmp(busy_vec);
    pop_cmp({31'd0, idle});
    pop_cmp({31'd0, err_underflow});
  endtask

  task automatic check_fire(input string tag, input logic exp);
    push(tag, {31'd0, exp});
    #1;
    pop_cmp({31'd0, issue_fire});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    flush = 0; ds_valid = 0; es_allowin = 1; ds_we = 0; ds_dest = 0;
    ds_rs = 0; ds_rs_used = 0; ds_rt = 0; ds_rt_used = 0; ws_we = 0; ws_dest = 0;
  endtask

  task automatic issue(input logic [4:0] d);
    ds_valid = 1; ds_we = 1; ds_dest = d;
  endtask

  initial begin
    clr_in();
    reset = 1;
    step(); step();
    reset = 0;
    check_state("reset", 0, 32'h0, 1, 0);

    // Independent read, nothing pending.
    ds_valid = 1; ds_rs = 5; ds_rs_used = 1;
    check_state("t1", 0, 32'h0, 1, 0);
    check_fire("t1_fire", 1);

    // Writer to $8, then a reader of rt=$8.
    clr_in(); issue(8);
    check_fire("t2_issue", 1);
    step();
    clr_in(); ds_valid = 1; ds_rt = 8; ds_rt_used = 1;
    check_state("t2_n1", 1, 32'h100, 0, 0);
    check_fire("t2_n1_fire", 0);
    step();
    check_state("t2_n2", 1, 32'h100, 0, 0);
    ws_we = 1; ws_dest = 8;
    check_state("t2_ret", 1, 32'h100, 0, 0);
    step();
    ws_we = 0;
    check_state("t2_m1", 0, 32'h0, 1, 0);
    check_fire("t2_m1_fire", 1);

    // Three writers to $3 fill it; a fourth stalls until one retires.
    clr_in(); issue(3);
    check_fire("t3_w1", 1);
    step();
    check_fire("t3_w2", 1);
    step();
    check_fire("t3_w3", 1);
    step();
    check_state("t3_full", 1, 32'h8, 0, 0);
    check_fire("t3_full_fire", 0);
    ws_we = 1; ws_dest = 3;
    step();
    ws_we = 0;
    check_state("t3_release", 0, 32'h8, 0, 0);
    check_fire("t3_release_fire", 1);
    ds_valid = 0;
    ws_we = 1; ws_dest = 3;
    step(); step();
    ws_we = 0;
    check_state("t3_drain", 0, 32'h0, 1, 0);

    // Issue and retire of $4 in the same cycle leave cnt[4] and tot alone.
    clr_in(); issue(4);
    step();
    ws_we = 1; ws_dest = 4;
    check_fire("t4_both_fire", 1);
    step();
    clr_in();
    check_state("t4_same", 0, 32'h10, 0, 0);
    ws_we = 1; ws_dest = 4;
    step();
    ws_we = 0;
    check_state("t4_drain", 0, 32'h0, 1, 0);

    // Flush discards pending writers and the issue of its own cycle.
    clr_in(); issue(2);
    step();
    issue(9);
    step();
    check_state("t5_pend", 0, 32'h204, 0, 0);
    issue(10); flush = 1;
    check_fire("t5_flush_fire", 0);
    step();
    clr_in();
    check_state("t5_after", 0, 32'h0, 1, 0);

    // Retire of an empty register: sticky error, counters stay zero.
    ws_we = 1; ws_dest = 7;
    step();
    ws_we = 0;
    check_state("t6_under", 0, 32'h0, 1, 1);
    step();
    check_state("t6_sticky", 0, 32'h0, 1, 1);

    // $0 is never tracked.
    issue(0);
    check_fire("t7_d0_fire", 1);
    step();
    clr_in(); ds_valid = 1; ds_rs = 0; ds_rs_used = 1; ds_rt = 0; ds_rt_used = 1; ds_we = 1; ds_dest = 0;
    check_state("t7_r0", 0, 32'h0, 1, 1);

    // Reset mid-operation also clears the sticky error.
    clr_in(); issue(5);
    step();
    clr_in();
    check_state("t8_pend", 0, 32'h20, 0, 1);
    reset = 1;
    step();
    reset = 0;
    check_state("t8_reset", 0, 32'h0, 1, 0);

    if (sb.size() != 0) begin
      nfail++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
